// File: rtl/vid_frame_monitor_if.sv
// ----------------------------------------------------------------------------
// vid_frame_monitor_if
//   Parallel video timing/pixel bundle (hsync, vsync, active, data) as it
//   travels from the AXI-stream-to-video converter to the display encoder.
//
//   Parameters : DATA_BITS - pixel width
//   Modports   : master - drives the bundle (source side)
//                slave  - receives the bundle (sink side)
// ----------------------------------------------------------------------------
interface vid_frame_monitor_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 hsync;
    logic                 vsync;
    logic                 active;
    logic [DATA_BITS-1:0] data;

    modport master (output hsync, output vsync, output active, output data);
    modport slave  (input  hsync, input  vsync, input  active, input  data);
endinterface

// File: rtl/vid_frame_monitor.sv
// ----------------------------------------------------------------------------
// vid_frame_monitor
//   Inline video checker. Delays the video bundle by one register stage and
//   measures every frame: active pixels per line, cycles per line, active
//   lines and total lines per frame. Flags line-length errors, active-line
//   count errors and upstream FIFO underflow during active video, and counts
//   completed frames.
//
//   Ports
//     vid_clk, vid_rstn  : video clock, asynchronous active-low reset
//     vid_in  (slave)    : upstream hsync/vsync/active/data
//     vid_out (master)   : same bundle delayed by exactly one cycle
//     underflow_in       : upstream FIFO empty flag
//     err_clr            : single-cycle clear of err_sticky (a same-cycle set wins)
//     meas_h_active/meas_h_total/meas_v_active/meas_v_total
//                        : measurements of the last complete frame
//     frame_cnt          : completed frames, wraps
//     frame_done         : one-cycle pulse when measurements update
//     frame_ok           : last complete frame had no error
//     err_sticky         : bit0 line length, bit1 line count, bit2 underflow
//
//   Build option
//     VID_FRAME_MONITOR_BLANK_ON_UFL_EN : when defined, pixel data is forced
//     to zero on cycles where underflow_in and active are both high.
// ----------------------------------------------------------------------------
module vid_frame_monitor #(
    parameter int   DATA_BITS = 8,
    parameter int   H_DISP    = 1280,
    parameter int   V_DISP    = 960,
    parameter logic H_POL     = 1'b0,
    parameter logic V_POL     = 1'b1,
    parameter int   CNT_BITS  = 16
) (
    input  logic                     vid_clk,
    input  logic                     vid_rstn,
    vid_frame_monitor_if.slave       vid_in,
    vid_frame_monitor_if.master      vid_out,
    input  logic                     underflow_in,
    input  logic                     err_clr,
    output logic [CNT_BITS-1:0]      meas_h_active,
    output logic [CNT_BITS-1:0]      meas_h_total,
    output logic [CNT_BITS-1:0]      meas_v_active,
    output logic [CNT_BITS-1:0]      meas_v_total,
    output logic [CNT_BITS-1:0]      frame_cnt,
    output logic                     frame_done,
    output logic                     frame_ok,
    output logic [2:0]               err_sticky
);

    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] H_DISP_C = CNT_BITS'(H_DISP);
    localparam logic [CNT_BITS-1:0] V_DISP_C = CNT_BITS'(V_DISP);

    typedef enum logic {ST_SYNC, ST_RUN} state_t;
    state_t state_reg, state_next;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Passthrough stage and edge-detect history
    logic                 hs_reg, vs_reg, act_reg, ufl_reg;
    logic                 hs_prev_reg, vs_prev_reg, act_prev_reg;
    logic [DATA_BITS-1:0] data_reg, data_next;

    // Per-line / per-frame measurement state
    logic [CNT_BITS-1:0]  pix_cnt_reg, line_len_reg, act_lines_reg;
    logic [CNT_BITS-1:0]  tot_cnt_reg, h_total_reg, tot_lines_reg;
    logic                 frame_len_err_reg, frame_ufl_err_reg;
    logic [2:0]           err_sticky_reg, err_sticky_next, err_set;

    logic                 hs_lead, vs_lead, act_fall, run, counting;
    logic                 line_close, len_bad, cnt_bad, ufl_hit, frame_end;
    logic [CNT_BITS-1:0]  act_lines_fin;

`ifdef VID_FRAME_MONITOR_BLANK_ON_UFL_EN
    assign data_next = (underflow_in && vid_in.active) ? '0 : vid_in.data;
`else
    assign data_next = vid_in.data;
`endif

    // Edges are taken on the registered copy, so every status update lands
    // two cycles after the corresponding input event.
    assign hs_lead  = (hs_reg == H_POL) && (hs_prev_reg != H_POL);
    assign vs_lead  = (vs_reg == V_POL) && (vs_prev_reg != V_POL);
    assign act_fall = act_prev_reg && !act_reg;

    assign run        = (state_reg == ST_RUN);
    assign counting   = run || vs_lead;   // first vsync edge starts a fresh frame
    assign line_close = run && act_fall;
    assign len_bad    = line_close && (pix_cnt_reg != H_DISP_C);
    assign ufl_hit    = run && ufl_reg;
    assign frame_end  = run && vs_lead;

    // A line closing on the vsync edge still belongs to the finishing frame.
    assign act_lines_fin = line_close ? sat_inc(act_lines_reg) : act_lines_reg;
    assign cnt_bad       = frame_end && (act_lines_fin != V_DISP_C);
    assign err_set       = {ufl_hit, cnt_bad, len_bad};

    // Per-bit sticky: a set in the same cycle as err_clr keeps that bit.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sticky
        assign err_sticky_next[gi] = err_set[gi] | (err_sticky_reg[gi] & ~err_clr);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_SYNC: if (vs_lead) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_SYNC;
        endcase
    end

    always_ff @(posedge vid_clk or negedge vid_rstn) begin
        if (!vid_rstn) begin
            state_reg <= ST_SYNC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge vid_clk or negedge vid_rstn) begin
        if (!vid_rstn) begin
            hs_reg            <= ~H_POL;
            vs_reg            <= ~V_POL;
            act_reg           <= 1'b0;
            ufl_reg           <= 1'b0;
            data_reg          <= '0;
            hs_prev_reg       <= ~H_POL;
            vs_prev_reg       <= ~V_POL;
            act_prev_reg      <= 1'b0;
            pix_cnt_reg       <= '0;
            line_len_reg      <= '0;
            act_lines_reg     <= '0;
            tot_cnt_reg       <= '0;
            h_total_reg       <= '0;
            tot_lines_reg     <= '0;
            frame_len_err_reg <= 1'b0;
            frame_ufl_err_reg <= 1'b0;
            err_sticky_reg    <= '0;
            meas_h_active     <= '0;
            meas_h_total      <= '0;
            meas_v_active     <= '0;
            meas_v_total      <= '0;
            frame_cnt         <= '0;
            frame_done        <= 1'b0;
            frame_ok          <= 1'b0;
        end else begin
            hs_reg         <= vid_in.hsync;
            vs_reg         <= vid_in.vsync;
            act_reg        <= vid_in.active;
            ufl_reg        <= underflow_in && vid_in.active;
            data_reg       <= data_next;
            hs_prev_reg    <= hs_reg;
            vs_prev_reg    <= vs_reg;
            act_prev_reg   <= act_reg;
            err_sticky_reg <= err_sticky_next;
            frame_done     <= frame_end;

            // While in SYNC without a vsync edge all counters stay at zero.
            if (counting) begin
                pix_cnt_reg <= act_reg ? sat_inc(pix_cnt_reg) : '0;
                if (line_close) line_len_reg <= pix_cnt_reg;

                tot_cnt_reg <= hs_lead ? CNT_ONE : sat_inc(tot_cnt_reg);
                if (hs_lead) h_total_reg <= tot_cnt_reg;

                if (vs_lead) begin
                    // A coincident hsync edge opens the first line of the new frame.
                    tot_lines_reg     <= hs_lead ? CNT_ONE : '0;
                    act_lines_reg     <= '0;
                    frame_len_err_reg <= 1'b0;
                    frame_ufl_err_reg <= 1'b0;
                end else begin
                    if (hs_lead) tot_lines_reg <= sat_inc(tot_lines_reg);
                    act_lines_reg     <= act_lines_fin;
                    frame_len_err_reg <= frame_len_err_reg | len_bad;
                    frame_ufl_err_reg <= frame_ufl_err_reg | ufl_hit;
                end
            end

            if (frame_end) begin
                meas_v_active <= act_lines_fin;
                meas_v_total  <= tot_lines_reg;
                meas_h_active <= line_close ? pix_cnt_reg : line_len_reg;
                meas_h_total  <= hs_lead ? tot_cnt_reg : h_total_reg;
                frame_ok      <= !(frame_len_err_reg | len_bad | cnt_bad |
                                   frame_ufl_err_reg | ufl_hit);
                frame_cnt     <= frame_cnt + CNT_ONE;
            end
        end
    end

    assign vid_out.hsync  = hs_reg;
    assign vid_out.vsync  = vs_reg;
    assign vid_out.active = act_reg;
    assign vid_out.data   = data_reg;
    assign err_sticky     = err_sticky_reg;

endmodule

// File: doc/vid_frame_monitor.md
# vid_frame_monitor

Video-domain checker placed directly downstream of the AXI-stream-to-video converter, between it and the display encoder. Passes hsync/vsync/active/data through a one-cycle register and measures every frame: active pixels per line, total cycles per line, active lines and total lines per frame. Flags geometry mismatches and upstream FIFO underflow during active video, and keeps a frame counter. Status feeds software and the `locked` diagnostics path.

## Interface
- DATA_BITS, 8, pixel width
- H_DISP, 1280, expected active pixels per line
- V_DISP, 960, expected active lines per frame
- H_POL, 1'b0, hsync asserted level
- V_POL, 1'b1, vsync asserted level
- CNT_BITS, 16, width of all measurement counters

- vid_clk  in  1  video clock
- vid_rstn  in  1  reset vid_rstn, asynchronous, active-low; clock vid_clk
- vid_hsync_in / vid_vsync_in / vid_active_in  in  1 each  upstream timing
- vid_data_in  in  DATA_BITS  upstream pixel
- underflow_in  in  1  upstream FIFO empty flag
- err_clr  in  1  single-cycle clear of err_sticky
- vid_hsync / vid_vsync / vid_active_video  out  1 each  registered timing
- vid_data  out  DATA_BITS  registered pixel
- meas_h_active / meas_h_total / meas_v_active / meas_v_total  out  CNT_BITS each  last complete frame's measurements
- frame_cnt  out  CNT_BITS  completed frames, wraps
- frame_done  out  1  one-cycle pulse when measurements update
- frame_ok  out  1  last complete frame had no error
- err_sticky  out  3  bit0 line-length error, bit1 line-count error, bit2 underflow

## Operation
- Edge detect: register vsync/hsync/active inputs; vsync leading edge = input at V_POL and previous not; same for hsync with H_POL; active falling edge = previous 1, current 0.
- FSM: SYNC (after reset, counters held at 0) -> RUN on first vsync leading edge; no frame_done for that edge. RUN stays until reset.
- Pixel counter: increments each cycle active_in=1; on active falling edge latch to line length, compare with H_DISP (mismatch sets frame line error and err_sticky[0]), increment active-line counter, clear pixel counter.
- Line-total counter: increments every cycle; on hsync leading edge latch as current h_total, restart at 1, increment total-line counter.
- Underflow: underflow_in=1 while active_in=1 sets frame underflow error and err_sticky[2].
- On vsync leading edge in RUN: meas_v_active=active-line count, meas_v_total=total-line count, meas_h_active=last latched line length, meas_h_total=last h_total; active-line count != V_DISP sets err_sticky[1]; frame_ok = no line/count/underflow error in the frame; frame_cnt+1; frame_done pulse; per-frame counters and errors cleared.
- All counters saturate at all-ones (never wrap) except frame_cnt.
- err_clr and a same-cycle error set: set wins for that bit, others clear.
- Active edge coinciding with vsync edge: line closes into the finishing frame first.

## Timing
- Passthrough latency exactly 1 cycle for all four video outputs.
- Measurements, frame_cnt, frame_ok, frame_done update 2 cycles after the vsync leading edge at the input (1 register + 1 detect).
- err_sticky bit visible 2 cycles after the offending input cycle.
- Reset: vid_hsync=~H_POL, vid_vsync=~V_POL, vid_active_video=0, vid_data=0, all meas_*=0, frame_cnt=0, frame_done=0, frame_ok=0, err_sticky=0, FSM=SYNC.
- Reset mid-frame: everything returns to reset values immediately; next vsync edge only resynchronises.

## Configuration
- VID_FRAME_MONITOR_BLANK_ON_UFL_EN defined: vid_data forced to 0 on any cycle where underflow_in=1 and active_in=1 (same 1-cycle latency); statistics unchanged.
- Undefined: vid_data always equals delayed vid_data_in.

## Test plan
- Params H_DISP=8, V_DISP=4, 4-cycle h-blank, 2 blank lines; clean frames -> 2nd vsync edge gives meas_h_active=8, meas_h_total=12, meas_v_active=4, meas_v_total=6, frame_ok=1, frame_cnt=1, err_sticky=0.
- One line with 7 active pixels -> frame_ok=0, err_sticky=3'b001; next clean frame frame_ok=1, sticky held until err_clr.
- Frame with 3 active lines -> err_sticky[1]=1, meas_v_active=3.
- underflow_in high 1 cycle during active -> err_sticky[2]=1; with macro, the corresponding vid_data=0 one cycle later; without, data passes.
- err_clr same cycle as new line error -> bit0 remains 1.
- Reset asserted mid-line -> outputs at reset values; first following vsync edge produces no frame_done, second does with correct counts.
